// File: rtl/proc_trace_pkg.sv
// Shared types for the TinyRV1 trace shadow pipeline and its commit FIFO.
package proc_trace_pkg;

  localparam int TRACE_W = 96;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] inst;
    logic [31:0] data;
  } trace_rec_t;

  typedef struct packed {
    logic        val;
    logic [31:0] addr;
    logic [31:0] inst;
  } stage_t;

  localparam stage_t BUBBLE = '0;

endpackage

// File: rtl/trace_fifo.sv
// Synchronous val/rdy FIFO of retired trace records with occupancy, full and empty status.
module trace_fifo
  import proc_trace_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_push,
  input  trace_rec_t             i_rec,
  output logic                   o_val,
  input  logic                   i_rdy,
  output trace_rec_t             o_rec,
  output logic [$clog2(DEPTH):0] o_occupancy,
  output logic                   o_full,
  output logic                   o_empty
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;

  logic [TRACE_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]      r_wr_ptr;
  logic [AW-1:0]      r_rd_ptr;
  logic [CNT_W-1:0]   r_count;

  logic w_pop;
  logic w_push;

  assign o_empty     = (r_count == '0);
  assign o_full      = (r_count == CNT_W'(DEPTH));
  assign o_val       = !o_empty;
  assign o_occupancy = r_count;
  assign o_rec       = trace_rec_t'(r_mem[r_rd_ptr]);

  // A push into a full FIFO is accepted only when the head leaves in the same cycle.
  assign w_pop  = i_rdy && !o_empty;
  assign w_push = i_push && (!o_full || w_pop);

  // NOTE: storage is deliberately left out of reset; the pointers and count alone
  // define which entries are live, so clearing the array buys nothing.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_rec;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/proc_commit_tracker.sv
// Shadows the TinyRV1 F/D/X/M/W pipeline from its trace port and retires one record
// per instruction reaching W into a commit FIFO, with a retire counter and drop flag.
module proc_commit_tracker
  import proc_trace_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [31:0]            trace_addr,
  input  logic [31:0]            trace_inst,
  input  logic [31:0]            trace_data,
  input  logic                   trace_stall,
  input  logic                   trace_squash,
  output logic                   commit_val,
  input  logic                   commit_rdy,
  output logic [31:0]            commit_addr,
  output logic [31:0]            commit_inst,
  output logic [31:0]            commit_data,
  output logic [31:0]            commit_count,
  output logic [$clog2(DEPTH):0] occupancy,
  output logic                   overflow
);

  stage_t      r_d, r_x, r_m, r_w;
  logic [31:0] r_commit_count;
  logic        r_overflow;

  logic        w_push;
  logic        w_pop;
  logic        w_full;
  logic        w_empty;
  trace_rec_t  w_rec;
  trace_rec_t  w_head;

  // NOTE: every register here is written with <= so that all stages sample the
  // pre-edge values of their neighbours; blocking writes would collapse the pipe.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_d <= BUBBLE;
      r_x <= BUBBLE;
      r_m <= BUBBLE;
      r_w <= BUBBLE;
    end else begin
      if (trace_squash) begin
        r_d <= BUBBLE;
        r_x <= r_d;
      end else if (trace_stall) begin
        r_d <= r_d;
        r_x <= BUBBLE;
      end else begin
        r_d <= '{val: 1'b1, addr: trace_addr, inst: trace_inst};
        r_x <= r_d;
      end
      r_m <= r_x;
      r_w <= r_m;
    end
  end

  // Writeback data arrives on the trace port in the same cycle the instruction sits in W.
  assign w_push = r_w.val;
  assign w_rec  = '{addr: r_w.addr, inst: r_w.inst, data: trace_data};
  assign w_pop  = !w_empty && commit_rdy;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_commit_count <= '0;
      r_overflow     <= 1'b0;
    end else begin
      if (w_push) r_commit_count <= r_commit_count + 32'd1;
      if (w_push && w_full && !w_pop) r_overflow <= 1'b1;
    end
  end

  trace_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .i_push     (w_push),
    .i_rec      (w_rec),
    .o_val      (commit_val),
    .i_rdy      (commit_rdy),
    .o_rec      (w_head),
    .o_occupancy(occupancy),
    .o_full     (w_full),
    .o_empty    (w_empty)
  );

  assign commit_addr  = w_head.addr;
  assign commit_inst  = w_head.inst;
  assign commit_data  = w_head.data;
  assign commit_count = r_commit_count;
  assign overflow     = r_overflow;

endmodule
